// File: rtl/vliw_pipeline_controller.sv
// ---------------------------------------------------------------------------
// vliw_pipeline_controller
//
// Hazard and sequencing controller for a two-slot (ALU + MEM) 5-stage VLIW
// pipeline. It looks at the register fields of the bundle sitting in IF/ID
// (p1) and at the resolved control flags of the bundle in ID/EX (p2). From
// these it drives the PC enable and PC source, the per-latch write enables
// and the per-latch flushes. It sequences load-use stalls, branch/jump
// redirects and the exception drain, and counts stall/drain cycles.
//
// Ports
//   clk                         pipeline clock, rising edge
//   reset                       asynchronous reset, active low
//   hold                        external debug freeze
//   p1_alu_rm/rn, p1_mem_rn/rd  source register fields of the IF/ID bundle
//   p1_srcValid                 valid bits {alu_rm, alu_rn, mem_rn, mem_rd}
//   p2_memRead, p2_mem_rd       load in ID/EX and its destination register
//   p2_isBranch, p2_alu_flag_N  conditional branch and its condition flag
//   p2_isJump                   unconditional jump in EX
//   p2_*_undefinedInstruction   per-slot decode faults
//   pcWrite, pcSel              PC enable; source 0 seq, 1 branch, 2 jump,
//                               3 exception vector
//   p1..p4_pipeline_regWrite    latch write enables
//   IF_flush, ID_flush, EX_flush clear p1/p2/p3 latches at the next edge
//   isException, excCause       exception pulse and {alu, mem} fault cause
//   stallCount                  saturating stall/drain cycle counter
// ---------------------------------------------------------------------------
module vliw_pipeline_controller #(
  parameter int LOAD_USE_STALL = 1,
  parameter int EXC_DRAIN      = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [2:0]       p1_alu_rm,
  input  logic [2:0]       p1_alu_rn,
  input  logic [2:0]       p1_mem_rn,
  input  logic [2:0]       p1_mem_rd,
  input  logic [3:0]       p1_srcValid,
  input  logic             p2_memRead,
  input  logic [2:0]       p2_mem_rd,
  input  logic             p2_isBranch,
  input  logic             p2_alu_flag_N,
  input  logic             p2_isJump,
  input  logic             p2_alu_undefinedInstruction,
  input  logic             p2_mem_undefinedInstruction,
  output logic             pcWrite,
  output logic [1:0]       pcSel,
  output logic             p1_pipeline_regWrite,
  output logic             p2_pipeline_regWrite,
  output logic             p3_pipeline_regWrite,
  output logic             p4_pipeline_regWrite,
  output logic             IF_flush,
  output logic             ID_flush,
  output logic             EX_flush,
  output logic             isException,
  output logic [1:0]       excCause,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, REDIRECT} state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(EXC_DRAIN - 1);

  state_t           state, state_next;
  logic [2:0]       cnt, cnt_next;
  logic [1:0]       exc_cause_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic exc_any;
  logic branch_taken;
  logic redirect_any;
  logic load_use;
  logic run_stall;
  logic count_cycle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Event decode. A field only counts as a hazard source when its valid bit
  // is set, so unused operand slots never cause a stall.
  always_comb begin
    exc_any      = p2_alu_undefinedInstruction | p2_mem_undefinedInstruction;
    branch_taken = p2_isBranch & p2_alu_flag_N;
    redirect_any = p2_isJump | branch_taken;
    load_use     = p2_memRead &
                   ((p1_srcValid[3] & (p1_alu_rm == p2_mem_rd)) |
                    (p1_srcValid[2] & (p1_alu_rn == p2_mem_rd)) |
                    (p1_srcValid[1] & (p1_mem_rn == p2_mem_rd)) |
                    (p1_srcValid[0] & (p1_mem_rd == p2_mem_rd)));
    // Exceptions and redirects both squash the bundle in IF/ID, so a
    // load-use condition alongside them needs no bubble.
    run_stall    = (state == RUN) & ~exc_any & ~redirect_any & load_use;
    count_cycle  = ~hold & ((state == STALL) | (state == DRAIN) | run_stall);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cnt         <= 3'd0;
      exc_cause_q <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (isException)
        exc_cause_q <= {p2_alu_undefinedInstruction, p2_mem_undefinedInstruction};
      if (count_cycle)
        stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // Next-state logic. The counter holds the number of cycles still to be
  // spent in STALL (including the current one) or in DRAIN after this one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!hold) begin
      case (state)
        RUN: begin
          if (exc_any) begin
            state_next = DRAIN;
            cnt_next   = DRAIN_INIT;
          end else if (run_stall && (LOAD_USE_STALL > 1)) begin
            state_next = STALL;
            cnt_next   = STALL_INIT;
          end
        end
        STALL: begin
          cnt_next = cnt - 3'd1;
          if (cnt <= 3'd1)
            state_next = RUN;
        end
        DRAIN: begin
          if (cnt == 3'd0)
            state_next = REDIRECT;
          else
            cnt_next = cnt - 3'd1;
        end
        REDIRECT: state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  // Output logic. Reset low or hold high forces every enable and flush off.
  always_comb begin
    pcWrite              = 1'b0;
    pcSel                = 2'd0;
    p1_pipeline_regWrite = 1'b0;
    p2_pipeline_regWrite = 1'b0;
    p3_pipeline_regWrite = 1'b0;
    p4_pipeline_regWrite = 1'b0;
    IF_flush             = 1'b0;
    ID_flush             = 1'b0;
    EX_flush             = 1'b0;
    isException          = 1'b0;
    if (reset && !hold) begin
      case (state)
        RUN: begin
          pcWrite              = 1'b1;
          p1_pipeline_regWrite = 1'b1;
          p2_pipeline_regWrite = 1'b1;
          p3_pipeline_regWrite = 1'b1;
          p4_pipeline_regWrite = 1'b1;
          if (exc_any) begin
            isException = 1'b1;
            IF_flush    = 1'b1;
            ID_flush    = 1'b1;
            EX_flush    = 1'b1;
            pcWrite     = 1'b0;
          end else if (p2_isJump) begin
            pcSel    = 2'd2;
            IF_flush = 1'b1;
            ID_flush = 1'b1;
          end else if (branch_taken) begin
            pcSel    = 2'd1;
            IF_flush = 1'b1;
            ID_flush = 1'b1;
          end else if (load_use) begin
            pcWrite              = 1'b0;
            p1_pipeline_regWrite = 1'b0;
            ID_flush             = 1'b1;
          end
        end
        STALL: begin
          p2_pipeline_regWrite = 1'b1;
          p3_pipeline_regWrite = 1'b1;
          p4_pipeline_regWrite = 1'b1;
          ID_flush             = 1'b1;
        end
        DRAIN: begin
          p3_pipeline_regWrite = 1'b1;
          p4_pipeline_regWrite = 1'b1;
          IF_flush             = 1'b1;
          ID_flush             = 1'b1;
        end
        REDIRECT: begin
          pcSel                = 2'd3;
          pcWrite              = 1'b1;
          p1_pipeline_regWrite = 1'b1;
          p2_pipeline_regWrite = 1'b1;
          p3_pipeline_regWrite = 1'b1;
          p4_pipeline_regWrite = 1'b1;
          IF_flush             = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The cause is visible in the same cycle as the pulse and then held.
  assign excCause   = isException ?
                      {p2_alu_undefinedInstruction, p2_mem_undefinedInstruction} :
                      exc_cause_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_vliw_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_vliw_pipeline_controller
//
// Drives two controllers from the same inputs: instance a with the default
// parameters (1 stall cycle, 2 drain cycles, 16-bit counter) and instance b
// with 3 stall cycles, 1 drain cycle and a 3-bit counter so saturation is
// reached. A reference model tracks remaining stall/drain cycles and a
// pending redirect per instance and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_vliw_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic [2:0] p1_alu_rm, p1_alu_rn, p1_mem_rn, p1_mem_rd;
  logic [3:0] p1_srcValid;
  logic       p2_memRead;
  logic [2:0] p2_mem_rd;
  logic       p2_isBranch, p2_alu_flag_N, p2_isJump;
  logic       p2_alu_undef, p2_mem_undef;

  logic        a_pcWrite, a_rw1, a_rw2, a_rw3, a_rw4, a_iff, a_idf, a_exf, a_exc;
  logic [1:0]  a_pcSel, a_cause;
  logic [15:0] a_cnt;
  logic        b_pcWrite, b_rw1, b_rw2, b_rw3, b_rw4, b_iff, b_idf, b_exf, b_exc;
  logic [1:0]  b_pcSel, b_cause;
  logic [2:0]  b_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vliw_pipeline_controller #(.LOAD_USE_STALL(1), .EXC_DRAIN(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .hold(hold),
    .p1_alu_rm(p1_alu_rm), .p1_alu_rn(p1_alu_rn), .p1_mem_rn(p1_mem_rn),
    .p1_mem_rd(p1_mem_rd), .p1_srcValid(p1_srcValid),
    .p2_memRead(p2_memRead), .p2_mem_rd(p2_mem_rd),
    .p2_isBranch(p2_isBranch), .p2_alu_flag_N(p2_alu_flag_N), .p2_isJump(p2_isJump),
    .p2_alu_undefinedInstruction(p2_alu_undef), .p2_mem_undefinedInstruction(p2_mem_undef),
    .pcWrite(a_pcWrite), .pcSel(a_pcSel),
    .p1_pipeline_regWrite(a_rw1), .p2_pipeline_regWrite(a_rw2),
    .p3_pipeline_regWrite(a_rw3), .p4_pipeline_regWrite(a_rw4),
    .IF_flush(a_iff), .ID_flush(a_idf), .EX_flush(a_exf),
    .isException(a_exc), .excCause(a_cause), .stallCount(a_cnt)
  );

  vliw_pipeline_controller #(.LOAD_USE_STALL(3), .EXC_DRAIN(1), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .hold(hold),
    .p1_alu_rm(p1_alu_rm), .p1_alu_rn(p1_alu_rn), .p1_mem_rn(p1_mem_rn),
    .p1_mem_rd(p1_mem_rd), .p1_srcValid(p1_srcValid),
    .p2_memRead(p2_memRead), .p2_mem_rd(p2_mem_rd),
    .p2_isBranch(p2_isBranch), .p2_alu_flag_N(p2_alu_flag_N), .p2_isJump(p2_isJump),
    .p2_alu_undefinedInstruction(p2_alu_undef), .p2_mem_undefinedInstruction(p2_mem_undef),
    .pcWrite(b_pcWrite), .pcSel(b_pcSel),
    .p1_pipeline_regWrite(b_rw1), .p2_pipeline_regWrite(b_rw2),
    .p3_pipeline_regWrite(b_rw3), .p4_pipeline_regWrite(b_rw4),
    .IF_flush(b_iff), .ID_flush(b_idf), .EX_flush(b_exf),
    .isException(b_exc), .excCause(b_cause), .stallCount(b_cnt)
  );

  // Output vector layout: {pcWrite, pcSel, regWrite p1..p4, flush IF/ID/EX,
  // isException, excCause}
  logic [12:0] a_vec, b_vec;
  assign a_vec = {a_pcWrite, a_pcSel, a_rw1, a_rw2, a_rw3, a_rw4,
                  a_iff, a_idf, a_exf, a_exc, a_cause};
  assign b_vec = {b_pcWrite, b_pcSel, b_rw1, b_rw2, b_rw3, b_rw4,
                  b_iff, b_idf, b_exf, b_exc, b_cause};

  // Reference model state: cycles of stalling still owed, drain cycles still
  // owed, whether the exception-vector redirect is due, last cause, counter.
  typedef struct {
    int       stall_rem;
    int       drain_rem;
    bit       redir;
    logic [1:0] cause;
    int       cnt;
    int       cmax;
    int       L;
    int       D;
  } mdl_t;

  mdl_t m[2];

  task automatic init_models();
    for (int k = 0; k < 2; k++) begin
      m[k].stall_rem = 0;
      m[k].drain_rem = 0;
      m[k].redir     = 1'b0;
      m[k].cause     = 2'b00;
      m[k].cnt       = 0;
    end
    m[0].cmax = 65535; m[0].L = 1; m[0].D = 2;
    m[1].cmax = 7;     m[1].L = 3; m[1].D = 1;
  endtask

  function automatic bit hazard();
    logic [2:0] f[4];
    bit hit;
    f[0] = p1_alu_rm; f[1] = p1_alu_rn; f[2] = p1_mem_rn; f[3] = p1_mem_rd;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (p1_srcValid[3-i] && f[i] == p2_mem_rd) hit = 1'b1;
    return p2_memRead && hit;
  endfunction

  function automatic logic [12:0] model_out(input mdl_t s);
    logic pw; logic [1:0] ps; logic [3:0] rw; logic [2:0] fl; logic ie; logic [1:0] ca;
    pw = 1'b0; ps = 2'd0; rw = 4'b0000; fl = 3'b000; ie = 1'b0; ca = s.cause;
    if (!reset || hold) begin
      // everything off
    end else if (s.stall_rem > 0) begin
      rw = 4'b0111; fl = 3'b010;
    end else if (s.drain_rem > 0) begin
      rw = 4'b0011; fl = 3'b110;
    end else if (s.redir) begin
      pw = 1'b1; ps = 2'd3; rw = 4'b1111; fl = 3'b100;
    end else begin
      pw = 1'b1; rw = 4'b1111;
      if (p2_alu_undef || p2_mem_undef) begin
        ie = 1'b1; ca = {p2_alu_undef, p2_mem_undef}; fl = 3'b111; pw = 1'b0;
      end else if (p2_isJump) begin
        ps = 2'd2; fl = 3'b110;
      end else if (p2_isBranch && p2_alu_flag_N) begin
        ps = 2'd1; fl = 3'b110;
      end else if (hazard()) begin
        pw = 1'b0; rw = 4'b0111; fl = 3'b010;
      end
    end
    return {pw, ps, rw, fl, ie, ca};
  endfunction

  task automatic bump(input int k);
    if (m[k].cnt < m[k].cmax) m[k].cnt++;
  endtask

  task automatic advance(input int k);
    if (!reset) begin
      init_models();
    end else if (!hold) begin
      if (m[k].stall_rem > 0) begin
        m[k].stall_rem--; bump(k);
      end else if (m[k].drain_rem > 0) begin
        m[k].drain_rem--; bump(k);
        if (m[k].drain_rem == 0) m[k].redir = 1'b1;
      end else if (m[k].redir) begin
        m[k].redir = 1'b0;
      end else if (p2_alu_undef || p2_mem_undef) begin
        m[k].drain_rem = m[k].D;
        m[k].cause     = {p2_alu_undef, p2_mem_undef};
      end else if (p2_isJump || (p2_isBranch && p2_alu_flag_N)) begin
        // redirect only
      end else if (hazard()) begin
        bump(k);
        m[k].stall_rem = m[k].L - 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs currently applied: check, then step.
  task automatic cycle(input string tag);
    if (!reset) init_models();
    #2;
    check($sformatf("%s/a_out", tag), {3'b000, a_vec}, {3'b000, model_out(m[0])});
    check($sformatf("%s/b_out", tag), {3'b000, b_vec}, {3'b000, model_out(m[1])});
    check($sformatf("%s/a_cnt", tag), a_cnt, 16'(m[0].cnt));
    check($sformatf("%s/b_cnt", tag), {13'b0, b_cnt}, 16'(m[1].cnt));
    advance(0);
    advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hold = 1'b0;
    p1_alu_rm = 3'd0; p1_alu_rn = 3'd0; p1_mem_rn = 3'd0; p1_mem_rd = 3'd0;
    p1_srcValid = 4'b0000;
    p2_memRead = 1'b0; p2_mem_rd = 3'd0;
    p2_isBranch = 1'b0; p2_alu_flag_N = 1'b0; p2_isJump = 1'b0;
    p2_alu_undef = 1'b0; p2_mem_undef = 1'b0;
  endtask

  task automatic set_load_use();
    p2_memRead = 1'b1; p2_mem_rd = 3'd3; p1_alu_rn = 3'd3; p1_srcValid = 4'b0100;
  endtask

  initial begin
    init_models();
    clear_in();
    reset = 1'b0;
    cycle("reset0");
    cycle("reset1");
    reset = 1'b1;
    cycle("idle0");
    cycle("idle1");

    // Load-use hazard on alu_rn
    set_load_use();
    cycle("lu_hit");
    clear_in();
    for (int i = 0; i < 4; i++) cycle($sformatf("lu_after%0d", i));

    // Same fields but no valid bit set
    set_load_use(); p1_srcValid = 4'b0000;
    cycle("lu_novalid");
    clear_in();
    cycle("lu_novalid_after");

    // Taken branch squashes load-use, then not-taken branch leaves the stall
    set_load_use(); p2_isBranch = 1'b1; p2_alu_flag_N = 1'b1;
    cycle("br_taken_lu");
    p2_alu_flag_N = 1'b0;
    cycle("br_nt_lu");
    clear_in();
    for (int i = 0; i < 4; i++) cycle($sformatf("br_after%0d", i));

    // MEM-slot exception with a simultaneous jump
    p2_mem_undef = 1'b1; p2_isJump = 1'b1;
    cycle("exc0");
    clear_in();
    for (int i = 1; i < 6; i++) cycle($sformatf("exc%0d", i));

    // Hold mid-stall
    set_load_use();
    cycle("hold_lu");
    clear_in();
    cycle("hold_stall");
    hold = 1'b1;
    for (int i = 0; i < 4; i++) cycle($sformatf("hold%0d", i));
    hold = 1'b0;
    for (int i = 0; i < 4; i++) cycle($sformatf("hold_rel%0d", i));

    // Reset pulled low mid-drain
    p2_alu_undef = 1'b1;
    cycle("rst_exc");
    clear_in();
    cycle("rst_drain");
    reset = 1'b0;
    cycle("rst_mid");
    reset = 1'b1;
    cycle("rst_rel0");
    cycle("rst_rel1");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      hold          = ($urandom_range(0, 9) == 0);
      p1_alu_rm     = 3'($urandom_range(0, 3));
      p1_alu_rn     = 3'($urandom_range(0, 3));
      p1_mem_rn     = 3'($urandom_range(0, 3));
      p1_mem_rd     = 3'($urandom_range(0, 3));
      p1_srcValid   = 4'($urandom_range(0, 15));
      p2_memRead    = 1'($urandom_range(0, 1));
      p2_mem_rd     = 3'($urandom_range(0, 3));
      p2_isBranch   = ($urandom_range(0, 3) == 0);
      p2_alu_flag_N = 1'($urandom_range(0, 1));
      p2_isJump     = ($urandom_range(0, 7) == 0);
      p2_alu_undef  = ($urandom_range(0, 24) == 0);
      p2_mem_undef  = ($urandom_range(0, 24) == 0);
      cycle($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
